get_data_ctrl: RTL

Capture controller that sits directly downstream of the `get_data` software register in the user clock domain. It decodes the 32-bit control word written by the PowerPC (arm, continuous mode, abort, sample count), then drives the write port of a capture BRAM with a bounded burst of valid samples. It also returns a status word for a ppc-readable status register. Everything runs in `user_clk`; the control word arrives already synchronised by the register block.

---
 rtl/get_data_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/get_data_ctrl.sv
// ============================================================================
// Module  : get_data_ctrl
// Purpose : Decodes the get_data control word and writes bounded capture
//           bursts into a BRAM write port; optional macro GET_DATA_EXT_TRIG_EN
//           holds each burst until an external trigger.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module get_data_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       sw_ctrl,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              ext_trig,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [31:0]       status
);

  localparam int          CW       = ADDR_W + 1;
  localparam logic [31:0] DEPTH    = 32'd1 << ADDR_W;
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

`ifdef GET_DATA_EXT_TRIG_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_CAPTURE   = 3'd3,
    S_DONE      = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [31:0]         ctrl_q;
  logic                ctrl_prev_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       neff_q, neff_d;
  logic                done_q, done_d;
  logic                clamped_q, clamped_d;
  logic                armed_q, armed_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   baddr_q, baddr_d;
  logic [DATA_W-1:0]   bdin_q, bdin_d;

  logic                w_arm_edge;
  logic                w_abort;
  logic                w_start;
  logic                w_accept;
  logic                w_busy;
  logic [15:0]         w_n;
  logic                w_over;
  logic [CW-1:0]       w_neff;
  logic [CW-1:0]       w_cnt_inc;
  logic                w_unused;

  assign w_arm_edge = ctrl_q[0] & ~ctrl_prev_q;
  assign w_abort    = ctrl_q[2];
  assign w_n        = ctrl_q[31:16];
  assign w_over     = 32'(w_n) > DEPTH;
  assign w_neff     = ((w_n == 16'd0) || w_over) ? DEPTH_CW : CW'(w_n);
  assign w_cnt_inc  = cnt_q + CW'(1);

`ifdef GET_DATA_EXT_TRIG_EN
  // The trigger cycle itself already captures sample 0.
  assign w_start  = (state_q == S_CAPTURE) || ((state_q == S_WAIT_TRIG) && ext_trig);
  assign w_busy   = (state_q == S_ARMED) || (state_q == S_WAIT_TRIG) || (state_q == S_CAPTURE);
  assign w_unused = ^ctrl_q[15:3];
`else
  assign w_start  = (state_q == S_CAPTURE);
  assign w_busy   = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign w_unused = ^{ctrl_q[15:3], ext_trig};
`endif

  assign w_accept = w_start & din_valid & ~w_abort;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    neff_d    = neff_q;
    done_d    = done_q;
    clamped_d = clamped_q;
    armed_d   = (state_q == S_ARMED);
    we_d      = 1'b0;
    baddr_d   = baddr_q;
    bdin_d    = bdin_q;

    if (w_abort) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      cnt_d     = '0;
      done_d    = 1'b0;
      clamped_d = 1'b0;
      armed_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_arm_edge) begin
            state_d   = S_ARMED;
            neff_d    = w_neff;
            clamped_d = w_over;
          end
        end
`ifdef GET_DATA_EXT_TRIG_EN
        S_ARMED:     state_d = S_WAIT_TRIG;
        S_WAIT_TRIG: if (ext_trig) state_d = S_CAPTURE;
`else
        S_ARMED:     state_d = S_CAPTURE;
`endif
        S_CAPTURE:   state_d = S_CAPTURE;
        S_DONE: begin
          // A fresh arm re-latches the count; continuous re-entry reuses it.
          if (w_arm_edge) begin
            neff_d    = w_neff;
            clamped_d = w_over;
          end
          if (ctrl_q[1] || w_arm_edge) state_d = S_ARMED;
        end
        default:     state_d = S_IDLE;
      endcase

      if (w_accept) begin
        we_d    = 1'b1;
        baddr_d = addr_q;
        bdin_d  = din;
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = w_cnt_inc;
        if (w_cnt_inc == neff_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      if ((state_d == S_ARMED) && (state_q != S_ARMED)) begin
        done_d = 1'b0;
        addr_d = '0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      ctrl_prev_q <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      neff_q      <= '0;
      done_q      <= 1'b0;
      clamped_q   <= 1'b0;
      armed_q     <= 1'b0;
      we_q        <= 1'b0;
      baddr_q     <= '0;
      bdin_q      <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= sw_ctrl;
      ctrl_prev_q <= ctrl_q[0];
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      neff_q      <= neff_d;
      done_q      <= done_d;
      clamped_q   <= clamped_d;
      armed_q     <= armed_d;
      we_q        <= we_d;
      baddr_q     <= baddr_d;
      bdin_q      <= bdin_d;
    end
  end

  assign bram_we   = we_q;
  assign bram_addr = baddr_q;
  assign bram_din  = bdin_q;
  assign status    = {16'(cnt_q), 12'd0, armed_q, clamped_q, done_q, w_busy};

endmodule

`default_nettype wire
